// File: rtl/data_memory.sv
// Byte-wide data memory for the MEM stage: one synchronous write per clock,
// combinational gated read, synchronous clear of every location on reset.
module data_memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memReadSignal,
  input  logic                  memWriteSignal,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] dataOut
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] memArray_r [DEPTH];

  // Storage update: reset clears every word and overrides a same-edge write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        memArray_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (memWriteSignal) begin
      memArray_r[address] <= writeData;
    end
  end

  // Read path: combinational, forced to a driven zero when not reading.
  always_comb begin
    dataOut = {DATA_WIDTH{1'b0}};
    if (memReadSignal) begin
      dataOut = memArray_r[address];
    end else begin
      dataOut = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: stimulus pushes expected read data into a
// queue and a separate monitor pops and compares on each sample request.
module tb_data_memory;

  logic       clock;
  logic       reset;
  logic       memReadSignal;
  logic       memWriteSignal;
  logic [7:0] address;
  logic [7:0] writeData;
  logic [7:0] dataOut;

  typedef struct {
    logic [7:0] expData;
    string      name;
  } expItem_t;

  expItem_t expQ[$];
  event     sampleEv;
  int       checkCount = 0;
  int       errorCount = 0;

  data_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .memReadSignal (memReadSignal),
    .memWriteSignal(memWriteSignal),
    .address       (address),
    .writeData     (writeData),
    .dataOut       (dataOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: pops one expectation per sample request and compares dataOut.
  initial begin
    expItem_t item;
    forever begin
      @(sampleEv);
      checkCount++;
      if (expQ.size() == 0) begin
        errorCount++;
        $display("FAIL scoreboard_underflow: dataOut=%02h with no expectation queued", dataOut);
      end else begin
        item = expQ.pop_front();
        if (dataOut !== item.expData) begin
          errorCount++;
          $display("FAIL %s: dataOut=%02h expected=%02h", item.name, dataOut, item.expData);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic checkNow(input logic [7:0] expData, input string name);
    expItem_t item;
    #1;
    item.expData = expData;
    item.name    = name;
    expQ.push_back(item);
    ->sampleEv;
    #1;
  endtask

  task automatic writeWord(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    memReadSignal  = 1'b0;
    memWriteSignal = 1'b1;
    address        = a;
    writeData      = d;
    @(posedge clock);
    #1;
    memWriteSignal = 1'b0;
  endtask

  task automatic expectRead(input logic [7:0] a, input logic rd,
                            input logic [7:0] expData, input string name);
    @(negedge clock);
    memWriteSignal = 1'b0;
    address        = a;
    memReadSignal  = rd;
    checkNow(expData, name);
  endtask

  initial begin
    int waitCycles;
    reset          = 1'b1;
    memReadSignal  = 1'b0;
    memWriteSignal = 1'b0;
    address        = 8'h00;
    writeData      = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    expectRead(8'h00, 1'b1, 8'h00, "reset_addr00");
    expectRead(8'hFF, 1'b1, 8'h00, "reset_addrFF");
    expectRead(8'h42, 1'b0, 8'h00, "reset_idle_read");

    // Overwrite: last write wins
    writeWord(8'h00, 8'h06);
    writeWord(8'h00, 8'h04);
    expectRead(8'h00, 1'b1, 8'h04, "overwrite_addr00");

    // Independent locations
    writeWord(8'h06, 8'h09);
    writeWord(8'h00, 8'h08);
    expectRead(8'h06, 1'b1, 8'h09, "indep_addr06");
    expectRead(8'h00, 1'b1, 8'h08, "indep_addr00");
    expectRead(8'h07, 1'b1, 8'h00, "indep_unwritten07");

    // Write disable
    @(negedge clock);
    memWriteSignal = 1'b0;
    memReadSignal  = 1'b0;
    address        = 8'h06;
    writeData      = 8'hFF;
    @(posedge clock);
    expectRead(8'h06, 1'b1, 8'h09, "write_disable_addr06");

    // Read gating, then raise read enable without a clock edge
    expectRead(8'h06, 1'b0, 8'h00, "gated_read_low");
    memReadSignal = 1'b1;
    checkNow(8'h09, "gated_read_raised");

    // Read and write in the same cycle: old data before the edge, new after
    @(negedge clock);
    address        = 8'h20;
    writeData      = 8'h3C;
    memReadSignal  = 1'b1;
    memWriteSignal = 1'b1;
    checkNow(8'h00, "rw_same_cycle_before");
    @(posedge clock);
    checkNow(8'h3C, "rw_same_cycle_after");
    memWriteSignal = 1'b0;

    // Reset clears everything and drops the concurrent write
    writeWord(8'hFF, 8'h77);
    expectRead(8'hFF, 1'b1, 8'h77, "pre_reset_addrFF");
    @(negedge clock);
    reset          = 1'b1;
    memWriteSignal = 1'b1;
    memReadSignal  = 1'b0;
    address        = 8'h10;
    writeData      = 8'h55;
    @(posedge clock);
    #1;
    reset          = 1'b0;
    memWriteSignal = 1'b0;
    expectRead(8'h00, 1'b1, 8'h00, "post_reset_addr00");
    expectRead(8'h06, 1'b1, 8'h00, "post_reset_addr06");
    expectRead(8'hFF, 1'b1, 8'h00, "post_reset_addrFF");
    expectRead(8'h10, 1'b1, 8'h00, "post_reset_addr10");
    expectRead(8'h20, 1'b1, 8'h00, "post_reset_addr20");

    // Boundary addresses, writes resume after reset, no aliasing
    writeWord(8'hFF, 8'hA5);
    writeWord(8'h00, 8'h5A);
    expectRead(8'hFF, 1'b1, 8'hA5, "boundary_addrFF");
    expectRead(8'h00, 1'b1, 8'h5A, "boundary_addr00");
    expectRead(8'h7F, 1'b1, 8'h00, "boundary_alias7F");
    expectRead(8'h80, 1'b1, 8'h00, "boundary_alias80");

    // Drain the scoreboard with a bounded wait
    waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 20) begin
      @(negedge clock);
      waitCycles++;
    end
    if (expQ.size() != 0) begin
      errorCount++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
